// File: rtl/csr_trap_seq_if.sv
// Bus between the pipeline and the trap/MRET CSR write sequencer.
// Carries the trap/MRET requests, the CSR values read back from the CSR file,
// the WB-stage CSR write, the CSR file write port and the PC redirect.
interface csr_trap_seq_if;
  // requests from the pipeline
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_req;
  // current CSR values (asynchronous read from the CSR file)
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic [31:0] mstatus_in;
  // WB-stage CSR write
  logic        wb_csr_wen;
  logic [11:0] wb_csr_waddr;
  logic [31:0] wb_csr_wdata;
  // CSR file write port
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  // pipeline control
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // pipeline / CSR file side
  modport master (
    output trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    output mtvec_in, mepc_in, mstatus_in,
    output wb_csr_wen, wb_csr_waddr, wb_csr_wdata,
    input  csr_wen, csr_waddr, csr_wdata,
    input  busy, redirect_valid, redirect_pc
  );

  // sequencer side
  modport slave (
    input  trap_req, trap_cause, trap_pc, trap_tval, mret_req,
    input  mtvec_in, mepc_in, mstatus_in,
    input  wb_csr_wen, wb_csr_waddr, wb_csr_wdata,
    output csr_wen, csr_waddr, csr_wdata,
    output busy, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_seq.sv
// csr_trap_seq: writer side of the machine-mode CSR file.
// Sequences mepc/mcause/mtval/mstatus updates on a trap and the mstatus
// update on MRET through the single CSR write port, then issues a one-cycle
// PC redirect. In IDLE the WB-stage CSR write passes straight through.
// Optional build macro CSR_TRAP_VECTORED_EN: vectored interrupt targets when
// mtvec mode is 2'b01 and the latched cause is an interrupt.
module csr_trap_seq #(
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MTVAL_ADDR   = 12'h343
) (
  input logic           clk,
  input logic           rst,
  csr_trap_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MTVAL,
    T_MSTATUS,
    M_MSTATUS,
    REDIRECT
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] cause_reg;
  logic [31:0] pc_reg;
  logic [31:0] tval_reg;
  logic        trap_path_reg;     // 1 = trap sequence, 0 = MRET sequence
  logic [31:0] redirect_pc_reg;   // holds the last target after the pulse

  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;
  logic [31:0] mtvec_base;
  logic        unused_bits;

  // Fields that are never consumed: mtvec is only read, and the low bits of
  // mtvec/mepc are masked off when forming a target.
  assign unused_bits = ^{MTVEC_ADDR, bus.mtvec_in[1:0], bus.mepc_in[1:0]};

  // mstatus images for trap entry and MRET, derived from the live CSR value
  always_comb begin
    mstatus_trap        = bus.mstatus_in;
    mstatus_trap[7]     = bus.mstatus_in[3];   // MPIE <= MIE
    mstatus_trap[3]     = 1'b0;                // MIE  <= 0
    mstatus_trap[12:11] = 2'b11;               // MPP  <= M
    mstatus_mret        = bus.mstatus_in;
    mstatus_mret[3]     = bus.mstatus_in[7];   // MIE  <= MPIE
    mstatus_mret[7]     = 1'b1;                // MPIE <= 1
    mstatus_mret[12:11] = 2'b11;               // MPP  <= M (machine-only core)
  end

  // Redirect target: mtvec base (optionally vectored) for traps, mepc for MRET
  always_comb begin
    mtvec_base = {bus.mtvec_in[31:2], 2'b00};
    if (trap_path_reg) begin
      redirect_target = mtvec_base;
`ifdef CSR_TRAP_VECTORED_EN
      if (bus.mtvec_in[1:0] == 2'b01 && cause_reg[31]) begin
        redirect_target = mtvec_base + {cause_reg[29:0], 2'b00};
      end
`endif
    end else begin
      redirect_target = {bus.mepc_in[31:2], 2'b00};
    end
  end

  // State register; reset abandons any sequence in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request capture at acceptance and redirect target hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_reg       <= 32'd0;
      pc_reg          <= 32'd0;
      tval_reg        <= 32'd0;
      trap_path_reg   <= 1'b0;
      redirect_pc_reg <= 32'd0;
    end else begin
      if (state_reg == IDLE) begin
        if (bus.trap_req) begin
          cause_reg     <= bus.trap_cause;
          pc_reg        <= {bus.trap_pc[31:2], 2'b00};
          tval_reg      <= bus.trap_tval;
          trap_path_reg <= 1'b1;
        end else if (bus.mret_req) begin
          trap_path_reg <= 1'b0;
        end
      end
      if (state_reg == REDIRECT) begin
        redirect_pc_reg <= redirect_target;
      end
    end
  end

  // Next-state and write-port decode; IDLE forwards the WB-stage write
  always_comb begin
    state_next     = state_reg;
    csr_wen        = 1'b0;
    csr_waddr      = 12'd0;
    csr_wdata      = 32'd0;
    redirect_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        csr_wen   = bus.wb_csr_wen;
        csr_waddr = bus.wb_csr_waddr;
        csr_wdata = bus.wb_csr_wdata;
        // a trap outranks a simultaneous MRET, which is dropped
        if (bus.trap_req) begin
          state_next = T_MEPC;
        end else if (bus.mret_req) begin
          state_next = M_MSTATUS;
        end
      end
      T_MEPC: begin
        csr_wen    = 1'b1;
        csr_waddr  = MEPC_ADDR;
        csr_wdata  = pc_reg;
        state_next = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_wen    = 1'b1;
        csr_waddr  = MCAUSE_ADDR;
        csr_wdata  = cause_reg;
        state_next = T_MTVAL;
      end
      T_MTVAL: begin
        csr_wen    = 1'b1;
        csr_waddr  = MTVAL_ADDR;
        csr_wdata  = tval_reg;
        state_next = T_MSTATUS;
      end
      T_MSTATUS: begin
        csr_wen    = 1'b1;
        csr_waddr  = MSTATUS_ADDR;
        csr_wdata  = mstatus_trap;
        state_next = REDIRECT;
      end
      M_MSTATUS: begin
        csr_wen    = 1'b1;
        csr_waddr  = MSTATUS_ADDR;
        csr_wdata  = mstatus_mret;
        state_next = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.csr_wen        = csr_wen;
  assign bus.csr_waddr      = csr_waddr;
  assign bus.csr_wdata      = csr_wdata;
  assign bus.busy           = (state_reg != IDLE);
  assign bus.redirect_valid = redirect_valid;
  // target is presented during the pulse, then held from the register
  assign bus.redirect_pc    = (state_reg == REDIRECT) ? redirect_target : redirect_pc_reg;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Directed bench for csr_trap_seq: trap and MRET sequences, request priority,
// WB passthrough, reset mid-sequence and the optional vectored target.
// Build with +define+CSR_TRAP_VECTORED_EN to check the vectored variant.
module tb_csr_trap_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  csr_trap_seq_if bus ();

  csr_trap_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison: count it, report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect a sequencer write in the current cycle
  task automatic expect_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
    check({tag, ".wen"},  {31'd0, bus.csr_wen}, 32'd1);
    check({tag, ".addr"}, {20'd0, bus.csr_waddr}, {20'd0, addr});
    check({tag, ".data"}, bus.csr_wdata, data);
    check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
    $display("[TB] %s: wen=%0b addr=0x%03h data=0x%08h", tag, bus.csr_wen, bus.csr_waddr, bus.csr_wdata);
  endtask

  // Redirect cycle and the idle cycle after it
  task automatic expect_redirect(input string tag, input logic [31:0] pc);
    check({tag, ".rv"},   {31'd0, bus.redirect_valid}, 32'd1);
    check({tag, ".rpc"},  bus.redirect_pc, pc);
    check({tag, ".wen"},  {31'd0, bus.csr_wen}, 32'd0);
    check({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
    $display("[TB] %s: redirect_valid=%0b redirect_pc=0x%08h", tag, bus.redirect_valid, bus.redirect_pc);
    step();
    check({tag, ".rv_low"}, {31'd0, bus.redirect_valid}, 32'd0);
    check({tag, ".idle"},   {31'd0, bus.busy}, 32'd0);
    check({tag, ".hold"},   bus.redirect_pc, pc);
  endtask

  // Called in the acceptance cycle T of a trap: walks T+1..T+5
  task automatic trap_tail(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] mst,
                           input logic [31:0] target);
    step();
    bus.trap_req = 1'b0;
    bus.mret_req = 1'b0;
    bus.trap_pc  = 32'hFFFF_FFFF;  // latched copy must be used from here on
    #1;
    expect_write({tag, ".mepc"}, 12'h341, epc);
    step();
    expect_write({tag, ".mcause"}, 12'h342, cause);
    step();
    expect_write({tag, ".mtval"}, 12'h343, tval);
    step();
    expect_write({tag, ".mstatus"}, 12'h300, mst);
    step();
    expect_redirect({tag, ".redir"}, target);
  endtask

  task automatic set_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
    bus.trap_req   = 1'b1;
    bus.trap_cause = cause;
    bus.trap_pc    = pc;
    bus.trap_tval  = tval;
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        saw_redirect;
    logic [31:0] vec_target;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.trap_req = 1'b0;     bus.trap_cause = '0;  bus.trap_pc = '0;  bus.trap_tval = '0;
    bus.mret_req = 1'b0;     bus.mtvec_in = '0;    bus.mepc_in = '0;  bus.mstatus_in = '0;
    bus.wb_csr_wen = 1'b0;   bus.wb_csr_waddr = '0; bus.wb_csr_wdata = '0;

    step();
    step();
    // reset state
    check("reset.busy", {31'd0, bus.busy}, 32'd0);
    check("reset.rv",   {31'd0, bus.redirect_valid}, 32'd0);
    check("reset.rpc",  bus.redirect_pc, 32'd0);
    check("reset.wen",  {31'd0, bus.csr_wen}, 32'd0);
    $display("[TB] reset: busy=%0b redirect_valid=%0b redirect_pc=0x%08h", bus.busy, bus.redirect_valid, bus.redirect_pc);
    rst = 1'b0;
    step();

    // normal trap sequence
    bus.mstatus_in = 32'h0000_0008;
    bus.mtvec_in   = 32'h8000_0000;
    set_trap(32'd2, 32'h8000_0106, 32'hDEAD_BEEF);
    #1;
    check("trap.T.busy", {31'd0, bus.busy}, 32'd0);
    trap_tail("trap", 32'h8000_0104, 32'd2, 32'hDEAD_BEEF, 32'h0000_1880, 32'h8000_0000);

    // MRET
    bus.mstatus_in = 32'h0000_1880;
    bus.mepc_in    = 32'h8000_0108;
    bus.mret_req   = 1'b1;
    step();
    bus.mret_req = 1'b0;
    #1;
    expect_write("mret.mstatus", 12'h300, 32'h0000_1888);
    step();
    expect_redirect("mret.redir", 32'h8000_0108);

    // trap + MRET + WB write in the same cycle; WB write during sequence ignored
    bus.mstatus_in   = 32'h0000_0000;
    bus.mtvec_in     = 32'h0000_0200;
    bus.mret_req     = 1'b1;
    bus.wb_csr_wen   = 1'b1;
    bus.wb_csr_waddr = 12'h340;
    bus.wb_csr_wdata = 32'h0000_0055;
    set_trap(32'd5, 32'h0000_0100, 32'h0000_0000);
    #1;
    check("both.T.wen",  {31'd0, bus.csr_wen}, 32'd1);
    check("both.T.addr", {20'd0, bus.csr_waddr}, 32'h340);
    check("both.T.data", bus.csr_wdata, 32'h55);
    $display("[TB] both.T: wen=%0b addr=0x%03h data=0x%08h", bus.csr_wen, bus.csr_waddr, bus.csr_wdata);
    bus.wb_csr_waddr = 12'h7FF;
    bus.wb_csr_wdata = 32'h0000_1234;
    trap_tail("both", 32'h0000_0100, 32'd5, 32'd0, 32'h0000_1800, 32'h0000_0200);
    bus.wb_csr_wen = 1'b0;

    // reset asserted during T_MCAUSE
    bus.mstatus_in = 32'h0000_0008;
    bus.mtvec_in   = 32'h0000_1000;
    set_trap(32'd11, 32'h0000_0400, 32'd1);
    step();
    bus.trap_req = 1'b0;
    step();
    check("rstmid.addr", {20'd0, bus.csr_waddr}, 32'h342);
    rst = 1'b1;
    #1;
    check("rstmid.wen",  {31'd0, bus.csr_wen}, 32'd0);
    check("rstmid.busy", {31'd0, bus.busy}, 32'd0);
    check("rstmid.rpc",  bus.redirect_pc, 32'd0);
    $display("[TB] rstmid: wen=%0b busy=%0b", bus.csr_wen, bus.busy);
    step();
    rst = 1'b0;
    saw_redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.redirect_valid || bus.busy || bus.csr_wen) saw_redirect = 1'b1;
    end
    check("rstmid.quiet", {31'd0, saw_redirect}, 32'd0);
    set_trap(32'd3, 32'h0000_0804, 32'd9);
    trap_tail("restart", 32'h0000_0804, 32'd3, 32'd9, 32'h0000_1880, 32'h0000_1000);

    // vectored interrupt
`ifdef CSR_TRAP_VECTORED_EN
    vec_target = 32'h8000_001C;
`else
    vec_target = 32'h8000_0000;
`endif
    bus.mstatus_in = 32'h0000_0000;
    bus.mtvec_in   = 32'h8000_0001;
    set_trap(32'h8000_0007, 32'h0000_0000, 32'h0000_0000);
    trap_tail("vec", 32'h0000_0000, 32'h8000_0007, 32'd0, 32'h0000_1800, vec_target);

    // passthrough in IDLE
    bus.wb_csr_wen   = 1'b1;
    bus.wb_csr_waddr = 12'h305;
    bus.wb_csr_wdata = 32'h8000_0400;
    #1;
    check("pass.wen",  {31'd0, bus.csr_wen}, 32'd1);
    check("pass.addr", {20'd0, bus.csr_waddr}, 32'h305);
    check("pass.data", bus.csr_wdata, 32'h8000_0400);
    check("pass.busy", {31'd0, bus.busy}, 32'd0);
    $display("[TB] pass: wen=%0b addr=0x%03h data=0x%08h", bus.csr_wen, bus.csr_waddr, bus.csr_wdata);
    bus.wb_csr_wen = 1'b0;
    #1;
    check("pass.off", {31'd0, bus.csr_wen}, 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
